// File: rtl/bcd_seg_scan_pkg.sv
// Shared types and constants for the two-digit 7-segment scanner.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package bcd_seg_scan_pkg;

  typedef enum logic [1:0] {
    SHOW0 = 2'd0,
    GAP0  = 2'd1,
    SHOW1 = 2'd2,
    GAP1  = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [1:0] AN_OFF    = 2'b11;
  localparam logic [1:0] AN_ONES   = 2'b10;
  localparam logic [1:0] AN_TENS   = 2'b01;

  // Index 0 sits in the least significant slot, so the list reads 9 down to 0.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/bcd_seg_scan_if.sv
// Digit load bus into the scanner and the display drive coming out of it.
interface bcd_seg_scan_if;
  logic       load;
  logic       tens;
  logic [3:0] ones;
  logic [1:0] an;
  logic [6:0] seg;

  modport master (output load, tens, ones, input  an, seg);
  modport slave  (input  load, tens, ones, output an, seg);
endinterface

// File: rtl/bcd_seg_scan_bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; values above 9 show a dash.
module bcd_to_seg
  import bcd_seg_scan_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    if (i_digit <= 4'd9) o_seg = SEG_TABLE[i_digit];
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Latches a tens flag + ones digit and scans them onto a 2-digit common-anode display.
// Optional LEADING_ZERO_BLANK_EN darkens the tens digit when it would show a leading 0.
module bcd_seg_scan
  import bcd_seg_scan_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  bcd_seg_scan_if.slave  bus
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - BLANK_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam bit            HAS_GAP   = (BLANK_CYCLES > 0);

  logic          r_tens;
  logic [3:0]    r_ones;
  logic [CW-1:0] r_cnt;
  state_t        r_state;
  logic [1:0]    r_an;
  logic [6:0]    r_seg;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [3:0]    w_digit;
  logic [6:0]    w_dec;
  logic          w_dark;
  logic [1:0]    w_an;
  logic [6:0]    w_seg;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    case (r_state)
      SHOW0: if (r_cnt == SHOW_LAST) begin
        w_state_nxt = HAS_GAP ? GAP0 : SHOW1;
        w_cnt_nxt   = '0;
      end
      GAP0: if (r_cnt == GAP_LAST) begin
        w_state_nxt = SHOW1;
        w_cnt_nxt   = '0;
      end
      SHOW1: if (r_cnt == SHOW_LAST) begin
        w_state_nxt = HAS_GAP ? GAP1 : SHOW0;
        w_cnt_nxt   = '0;
      end
      GAP1: if (r_cnt == GAP_LAST) begin
        w_state_nxt = SHOW0;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = SHOW0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // One shared decoder; an invalid ones digit forces a dash on the tens digit too.
  always_comb begin
    w_digit = r_ones;
    w_an    = AN_OFF;
    w_dark  = 1'b1;
    case (r_state)
      SHOW0: begin
        w_digit = r_ones;
        w_an    = AN_ONES;
        w_dark  = 1'b0;
      end
      SHOW1: begin
        w_digit = (r_ones > 4'd9) ? 4'hF : {3'b000, r_tens};
        w_an    = AN_TENS;
        w_dark  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (!r_tens && (r_ones <= 4'd9)) begin
          w_an   = AN_OFF;
          w_dark = 1'b1;
        end
`endif
      end
      default: begin
        w_an   = AN_OFF;
        w_dark = 1'b1;
      end
    endcase
    w_seg = w_dark ? SEG_BLANK : w_dec;
  end

  bcd_to_seg u_dec (
    .i_digit (w_digit),
    .o_seg   (w_dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tens  <= 1'b0;
      r_ones  <= 4'd0;
      r_cnt   <= '0;
      r_state <= SHOW0;
      r_an    <= AN_OFF;
      r_seg   <= SEG_BLANK;
    end else begin
      if (bus.load) begin
        r_tens <= bus.tens;
        r_ones <= bus.ones;
      end
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
      r_an    <= w_an;
      r_seg   <= w_seg;
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed bench: one scanner with a 1-cycle gap and one with no gap, fed the same loads.
module tb_bcd_seg_scan;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bcd_seg_scan_if u_if ();
  bcd_seg_scan_if u_if0 ();

  assign u_if0.load = u_if.load;
  assign u_if0.tens = u_if.tens;
  assign u_if0.ones = u_if.ones;

  bcd_seg_scan #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  bcd_seg_scan #(.REFRESH_DIV(4), .BLANK_CYCLES(0)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if0.slave)
  );

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [1:0] LZ_AN  = 2'b11;
  localparam logic [6:0] LZ_SEG = 7'h7F;
`else
  localparam logic [1:0] LZ_AN  = 2'b01;
  localparam logic [6:0] LZ_SEG = 7'h40;
`endif

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_off(input string tag);
    check({tag, "_an"},   {6'b0, u_if.an},   8'h03);
    check({tag, "_seg"},  {1'b0, u_if.seg},  8'h7F);
    check({tag, "_an0"},  {6'b0, u_if0.an},  8'h03);
    check({tag, "_seg0"}, {1'b0, u_if0.seg}, 8'h7F);
  endtask

  // Phase p of the 8-cycle scan: gap DUT is 3 ones/1 off/3 tens/1 off, no-gap DUT is 4/4.
  task automatic check_phase(input int p, input logic [6:0] ones_seg,
                             input logic [1:0] tens_an, input logic [6:0] tens_seg);
    logic [1:0] ea;
    logic [6:0] es;
    tick;
    if (p < 3) begin
      ea = 2'b10; es = ones_seg;
    end else if (p == 3 || p == 7) begin
      ea = 2'b11; es = 7'h7F;
    end else begin
      ea = tens_an; es = tens_seg;
    end
    check($sformatf("gap_an_p%0d", p),  {6'b0, u_if.an},  {6'b0, ea});
    check($sformatf("gap_seg_p%0d", p), {1'b0, u_if.seg}, {1'b0, es});
    check("gap_an_not00", {7'b0, (u_if.an == 2'b00)}, 8'h00);
    if (p < 4) begin
      ea = 2'b10; es = ones_seg;
    end else begin
      ea = tens_an; es = tens_seg;
    end
    check($sformatf("nogap_an_p%0d", p),  {6'b0, u_if0.an},  {6'b0, ea});
    check($sformatf("nogap_seg_p%0d", p), {1'b0, u_if0.seg}, {1'b0, es});
  endtask

  // Check one full scan; optionally present new inputs before the final edge.
  task automatic run8(input logic [6:0] ones_seg, input logic [1:0] tens_an,
                      input logic [6:0] tens_seg, input bit do_load, input bit do_chg,
                      input logic t, input logic [3:0] o);
    for (int p = 0; p < 8; p++) begin
      check_phase(p, ones_seg, tens_an, tens_seg);
      if (p == 6 && (do_load || do_chg)) begin
        u_if.load = do_load;
        u_if.tens = t;
        u_if.ones = o;
      end
      if (p == 7) u_if.load = 1'b0;
    end
  endtask

  initial begin
    reset     = 1'b1;
    u_if.load = 1'b0;
    u_if.tens = 1'b0;
    u_if.ones = 4'd0;

    for (int i = 0; i < 3; i++) begin
      tick;
      check_off($sformatf("reset_c%0d", i));
    end
    reset = 1'b0;

    // Zero after reset, then load 17
    run8(7'h40, LZ_AN, LZ_SEG, 1'b1, 1'b0, 1'b1, 4'd7);
    run8(7'h78, 2'b01, 7'h79, 1'b1, 1'b0, 1'b0, 4'd12);
    // Error value; inputs change without load and must not show
    run8(7'h3F, 2'b01, 7'h3F, 1'b0, 1'b1, 1'b1, 4'd3);
    run8(7'h3F, 2'b01, 7'h3F, 1'b1, 1'b0, 1'b0, 4'd5);
    run8(7'h12, LZ_AN, LZ_SEG, 1'b0, 1'b0, 1'b0, 4'd0);

    // Reset in the second cycle of SHOW1
    for (int p = 0; p < 5; p++) check_phase(p, 7'h12, LZ_AN, LZ_SEG);
    reset = 1'b1;
    tick;
    check_off("midreset");
    reset = 1'b0;
    run8(7'h40, LZ_AN, LZ_SEG, 1'b0, 1'b0, 1'b0, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
